// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-addressed MOC RAM.
// State encoding, word geometry, read/write encodings and big-endian word packing.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  localparam int   WORD_BYTES = 4;
  localparam logic RD         = 1'b0;
  localparam logic WR         = 1'b1;

  // b0 is the byte at the lowest address and lands in the most significant lane.
  function automatic logic [31:0] be_word_pack(input logic [7:0] b0, input logic [7:0] b1,
                                               input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/byte_ram_array.sv
// 2**ADDR_W x 8 storage with four combinational read ports and four
// independently enabled byte write lanes; contents power up unknown.
module byte_ram_array
  import mem_pkg::*;
#(
  parameter int    ADDR_W    = 9,
  parameter string INIT_FILE = ""
) (
  input  logic                             clk,
  input  logic [WORD_BYTES-1:0][ADDR_W-1:0] rd_addr,
  output logic [WORD_BYTES-1:0][7:0]        rd_data,
  input  logic [WORD_BYTES-1:0]             wr_en,
  input  logic [WORD_BYTES-1:0][ADDR_W-1:0] wr_addr,
  input  logic [WORD_BYTES-1:0][7:0]        wr_data
);

  logic [7:0] mem [2**ADDR_W];

  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      rd_data[i] = mem[rd_addr[i]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (wr_en[i]) mem[wr_addr[i]] <= wr_data[i];
    end
  end

endmodule

// File: rtl/ram_moc_unit.sv
// Big-endian byte/word RAM with a MOC handshake and programmable wait latency.
// Optional MEM_ALIGN_CHECK_EN adds align_err and suppresses unaligned word accesses.
module ram_moc_unit
  import mem_pkg::*;
#(
  parameter int    ADDR_W    = 9,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable,
  input  logic        rw,
  input  logic        byte_mode,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        busy,
  output logic        align_err
`else
  output logic        busy
`endif
);

  // Handshake: mem_enable is sampled only in IDLE; moc stays high in DONE
  // until mem_enable is seen low, so each request needs a low cycle between.
  mem_state_t        state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              rw_q, byte_q, uns_q;
  logic              access_ok, misaligned, do_write, ext;

  logic [WORD_BYTES-1:0][ADDR_W-1:0] lane_addr;
  logic [WORD_BYTES-1:0][7:0]        rd_data;
  logic [WORD_BYTES-1:0]             wr_en;
  logic [WORD_BYTES-1:0][7:0]        wr_data;

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      data_q <= '0;
      rw_q   <= RD;
      byte_q <= 1'b0;
      uns_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (mem_enable) begin
          cnt    <= 4'(LATENCY - 1);
          addr_q <= addr[ADDR_W-1:0];
          data_q <= data_in;
          rw_q   <= rw;
          byte_q <= byte_mode;
          uns_q  <= unsigned_ld;
        end
        WAIT:    if (cnt != 4'd0) cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_enable) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    if (!mem_enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign moc  = (state == DONE);
  assign busy = (state != IDLE);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = !byte_q && (addr_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif
  assign access_ok = !misaligned;

  // Reset is gated in so a reset landing on the ACCESS edge drops the write.
  assign do_write = (state == ACCESS) && access_ok && (rw_q == WR) && !reset;

  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      lane_addr[i] = addr_q + ADDR_W'(i);
    end
    wr_en      = byte_q ? {3'b000, do_write} : {WORD_BYTES{do_write}};
    wr_data[0] = byte_q ? data_q[7:0] : data_q[31:24];
    wr_data[1] = data_q[23:16];
    wr_data[2] = data_q[15:8];
    wr_data[3] = data_q[7:0];
  end

  byte_ram_array #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .rd_addr (lane_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (lane_addr),
    .wr_data (wr_data)
  );

  assign ext = !uns_q && rd_data[0][7];

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if ((state == ACCESS) && access_ok && (rw_q == RD)) begin
      data_out <= byte_q ? {{24{ext}}, rd_data[0]}
                         : be_word_pack(rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      align_err <= 1'b0;
    end else if ((state == IDLE) && mem_enable) begin
      align_err <= 1'b0;
    end else if ((state == ACCESS) && misaligned) begin
      align_err <= 1'b1;
    end
  end
`endif

  logic unused_misaligned;
  assign unused_misaligned = misaligned;

endmodule

// File: tb/tb_ram_moc_unit.sv
// Directed scoreboard bench for ram_moc_unit (ADDR_W=9, LATENCY=2).
// Driver pushes expected data_out per request; a monitor pops on each moc rise.
module tb_ram_moc_unit;

  localparam int ADDR_W  = 9;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_enable = 1'b0;
  logic        rw = 1'b0;
  logic        byte_mode = 1'b0;
  logic        unsigned_ld = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        moc;
  logic        busy;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  ram_moc_unit #(
    .ADDR_W    (ADDR_W),
    .LATENCY   (LATENCY),
    .INIT_FILE ("")
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_enable  (mem_enable),
    .rw          (rw),
    .byte_mode   (byte_mode),
    .unsigned_ld (unsigned_ld),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .moc         (moc),
`ifdef MEM_ALIGN_CHECK_EN
    .busy        (busy),
    .align_err   (align_err)
`else
    .busy        (busy)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog sim_time_exceeded");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          cap_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        moc_prev = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (moc && !moc_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_moc actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        chk("data_out", data_out, exp_q.pop_front());
        if (cap_q.size() != 0) chk("moc_latency", 32'(cyc - cap_q.pop_front()), 32'(LATENCY + 1));
      end
    end
    moc_prev = moc;
  end

  // ---------------- driver ----------------
  // hold: number of cycles moc must be seen high with mem_enable held.
  // early_drop: mem_enable released on the first WAIT cycle.
  task automatic req(input logic rw_i, input logic bm_i, input logic uns_i,
                     input logic [31:0] a_i, input logic [31:0] d_i,
                     input logic [31:0] exp_i, input int hold, input bit early_drop);
    int t;
    int hi;
    exp_q.push_back(exp_i);
    rw = rw_i; byte_mode = bm_i; unsigned_ld = uns_i; addr = a_i; data_in = d_i;
    mem_enable = 1'b1;
    @(posedge clk);
    #1;
    cap_q.push_back(cyc);
    if (early_drop) begin
      @(negedge clk);
      mem_enable = 1'b0;
    end
    t = 0;
    while (!moc && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!moc) begin
      checks++;
      errors++;
      $display("FAIL moc_timeout actual=0 expected=1 addr=%h", a_i);
      mem_enable = 1'b0;
      return;
    end
    hi = 1;
    if (!early_drop) begin
      repeat (hold - 1) begin
        @(negedge clk);
        if (moc) hi++;
      end
      mem_enable = 1'b0;
    end
    chk("moc_high_cycles", 32'(hi), 32'(hold));
    @(negedge clk);
    chk("moc_fall", {31'b0, moc}, 32'd0);
    chk("busy_idle", {31'b0, busy}, 32'd0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    req(1'b1, 1'b0, 1'b0, a, d, e, 1, 1'b0);
  endtask
  task automatic wr_byte(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    req(1'b1, 1'b1, 1'b0, a, d, e, 1, 1'b0);
  endtask
  task automatic rd_word(input logic [31:0] a, input logic [31:0] e);
    req(1'b0, 1'b0, 1'b0, a, 32'h0, e, 1, 1'b0);
  endtask
  task automatic rd_byte(input logic [31:0] a, input logic uns, input logic [31:0] e);
    req(1'b0, 1'b1, uns, a, 32'h0, e, 1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stuck;
    repeat (3) @(negedge clk);
    chk("reset_moc", {31'b0, moc}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_data_out", data_out, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("reset_align_err", {31'b0, align_err}, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    wr_word(32'h10, 32'h11223344, 32'h0);
    rd_byte(32'h10, 1'b1, 32'h11);
    rd_byte(32'h11, 1'b1, 32'h22);
    rd_byte(32'h12, 1'b1, 32'h33);
    rd_byte(32'h13, 1'b1, 32'h44);
    wr_byte(32'h12, 32'hFFFFFFAB, 32'h44);
    rd_word(32'h10, 32'h1122AB44);
    wr_byte(32'h13, 32'h00000080, 32'h1122AB44);
    rd_byte(32'h13, 1'b0, 32'hFFFFFF80);
    rd_byte(32'h13, 1'b1, 32'h00000080);

`ifndef MEM_ALIGN_CHECK_EN
    // Word straddling the top of the array wraps to byte 0.
    wr_word(32'h1FE, 32'hDEADBEEF, 32'h80);
    rd_byte(32'h1FE, 1'b1, 32'hDE);
    rd_byte(32'h1FF, 1'b1, 32'hAD);
    rd_byte(32'h000, 1'b1, 32'hBE);
    rd_byte(32'h001, 1'b1, 32'hEF);
    rd_byte(32'h000, 1'b0, 32'hFFFFFFBE);
    rd_word(32'h1FE, 32'hDEADBEEF);
`endif
    rd_word(32'h10, 32'h1122AB80);
    wr_word(32'h20, 32'h01020304, 32'h1122AB80);

    // Reset on the first WAIT cycle aborts the write.
    rw = 1'b1; byte_mode = 1'b0; addr = 32'h20; data_in = 32'h00000055;
    mem_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mem_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    stuck = 0;
    repeat (6) begin
      @(negedge clk);
      if (moc) stuck++;
    end
    chk("abort_moc_cycles", 32'(stuck), 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_data_out", data_out, 32'd0);

    req(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h01020304, 5, 1'b0);
    req(1'b1, 1'b0, 1'b0, 32'h24, 32'hCAFEF00D, 32'h01020304, 1, 1'b1);
    rd_word(32'h24, 32'hCAFEF00D);
    rd_byte(32'h27, 1'b0, 32'h0000000D);

`ifdef MEM_ALIGN_CHECK_EN
    rd_word(32'h21, 32'h0000000D);
    chk("align_err_set", {31'b0, align_err}, 32'd1);
    rd_byte(32'h21, 1'b1, 32'h02);
    chk("align_err_clear", {31'b0, align_err}, 32'd0);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
